sigmoid_inverse: RTL and testbench
==================================

// Module: sigmoid_inverse
// PURPOSE
//  Streaming inverse of the PLAN sigmoid (logit): maps a 16-bit probability (Q3.12, 1.0=0x1000)
//  back to a signed Q8.24 activation. Used on the DBN reconstruction / top-down path.
//  3-stage pipeline with valid/ready handshake and a saturation event counter.
// PARAMETERS
//  SAT_CNT_W   16   width of saturation event counter (saturates at all-ones)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  in_valid    in   1    in_data valid
//  in_ready    out  1    block accepts in_data this cycle
//  in_data     in   16   probability, Q3.12 unsigned (0x1000 = 1.0)
//  out_valid   out  1    out_data/out_sat valid
//  out_ready   in   1    downstream accepts this cycle
//  out_data    out  32   activation, signed two's-complement Q8.24
//  out_sat     out  1    result was clamped to +/-5.0
//  sat_clr     in   1    synchronous clear of sat_count
//  sat_count   out  SAT_CNT_W  number of saturated results transferred on output
// BEHAVIOUR
//  Reset (async, rst_n=0): all stage valids=0, out_valid=0, out_data=0, out_sat=0, sat_count=0.
//  Handshake: adv = ~out_valid | out_ready; in_ready = adv. Transfer on in_valid&in_ready /
//   out_valid&out_ready. All 3 stages shift together when adv=1; hold when adv=0.
//   Bubbles are not collapsed. Latency 3 cycles from accept to out_valid with out_ready=1.
//   out_data/out_sat stable while out_valid=1 & out_ready=0.
//  Stage 1 (fold/clamp):
//   - in_data > 0x1000 (incl. bit15 set) -> clamp to 0x1000.
//   - neg = (y < 0x0800); y' = neg ? 0x1000 - y : y. Range y' in [0x0800, 0x1000].
//  Stage 2 (segment select, subtract offset, 16-bit unsigned):
//   - y' <  0x0C00 : d = y' - 0x0800, sh = 2
//   - y' <  0x0EC0 : d = y' - 0x0A00, sh = 3
//   - y' <  0x1000 : d = y' - 0x0D80, sh = 5
//   - y' == 0x1000 : sat = 1, x = 0x5000 (5.0 in Q.12)
//  Stage 3 (scale, sign, widen):
//   - x = d << sh, in Q3.12; max 0x5000, no overflow in 16 bits.
//   - mag32 = {4'b0, x, 12'b0}  (Q.12 -> Q8.24).
//   - out_data = neg ? -mag32 : mag32; out_sat = sat. y=0x0800 gives exactly 0 (no -0).
//  Boundaries:
//   - y=0x0000 -> -5.0 (0xFB00_0000), sat.
//   - y>=0x1000 -> +5.0 (0x0500_0000), sat.
//   - 0x0EC0 belongs to segment 3 (decided; +2.5, not 2.375).
//  sat_count: +1 on each output transfer with out_sat=1; holds at 2^SAT_CNT_W-1.
//   sat_clr has priority over a simultaneous increment (result 0).
//  Reset mid-stream: in-flight data discarded, no output transfer for it.
// TESTING
//  T1  in 0x0800,0x0A00,0x0C00,0x0F00 back-to-back, out_ready=1 ->
//      0x0000_0000, 0x0080_0000, 0x0100_0000, 0x0300_0000 on cycles 3..6, out_sat=0.
//  T2  in 0x0400, 0x0000 -> 0xFF00_0000 (sat=0); 0xFB00_0000 (sat=1).
//  T3  in 0x1000, 0x8123, 0x0EC0 -> 0x0500_0000 sat=1; 0x0500_0000 sat=1;
//      0x0280_0000 sat=0; sat_count=2.
//  T4  stream 8 values, out_ready toggled pseudo-randomly -> outputs in order,
//      none lost/duplicated; in_ready=0 exactly when out_valid=1 & out_ready=0.
//  T5  drive 0xFFFF+2 saturating transfers -> sat_count holds 0xFFFF;
//      sat_clr with concurrent sat transfer -> 0.
//  T6  assert rst_n low with 3 items in flight -> out_valid=0 immediately, no stale output
//      after release; sweep all 0x0000..0x1000 vs reference model (T1 rules).

Source files
------------

// File: rtl/sigmoid_inverse.sv
// Streaming logit (inverse PLAN sigmoid): Q3.12 probability in, signed Q8.24 activation out.
// Three-stage fold / segment / scale pipeline with a valid-ready handshake and a saturation counter.
module sigmoid_inverse #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_sat,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);

  logic                 adv_s;
  logic [15:0]          y_clamp_s;

  logic                 s1_valid_q;
  logic                 s1_neg_q, s1_neg_d;
  logic [15:0]          s1_y_q, s1_y_d;

  logic                 s2_valid_q;
  logic                 s2_neg_q;
  logic                 s2_sat_q, s2_sat_d;
  logic [15:0]          s2_dif_q, s2_dif_d;
  logic [2:0]           s2_sh_q, s2_sh_d;

  logic                 out_valid_q;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;
  logic [15:0]          x_s;
  logic [31:0]          mag_s;

  logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv_s    = ~out_valid_q | out_ready;
  assign in_ready = adv_s;

  // Stage 1: clamp out-of-range probabilities and fold the lower half onto the upper half.
  always_comb begin
    if (in_data > 16'h1000) begin
      y_clamp_s = 16'h1000;
    end else begin
      y_clamp_s = in_data;
    end
    s1_neg_d = (y_clamp_s < 16'h0800);
    if (s1_neg_d) begin
      s1_y_d = 16'h1000 - y_clamp_s;
    end else begin
      s1_y_d = y_clamp_s;
    end
  end

  // Stage 2: pick the linear segment; 0x0EC0 deliberately falls into the steep segment.
  always_comb begin
    s2_sat_d = 1'b0;
    s2_dif_d = 16'h0000;
    s2_sh_d  = 3'd0;
    if (s1_y_q < 16'h0C00) begin
      s2_dif_d = s1_y_q - 16'h0800;
      s2_sh_d  = 3'd2;
    end else if (s1_y_q < 16'h0EC0) begin
      s2_dif_d = s1_y_q - 16'h0A00;
      s2_sh_d  = 3'd3;
    end else if (s1_y_q < 16'h1000) begin
      s2_dif_d = s1_y_q - 16'h0D80;
      s2_sh_d  = 3'd5;
    end else begin
      s2_sat_d = 1'b1;
    end
  end

  // Stage 3: scale, widen Q.12 to Q8.24 and apply the sign recorded by the fold.
  always_comb begin
    if (s2_sat_q) begin
      x_s = 16'h5000;
    end else begin
      x_s = s2_dif_q << s2_sh_q;
    end
    mag_s = {4'b0000, x_s, 12'h000};
    if (s2_neg_q) begin
      out_data_d = 32'h0000_0000 - mag_s;
    end else begin
      out_data_d = mag_s;
    end
    out_sat_d = s2_sat_q;
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_neg_q    <= 1'b0;
      s1_y_q      <= 16'h0000;
      s2_valid_q  <= 1'b0;
      s2_neg_q    <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_dif_q    <= 16'h0000;
      s2_sh_q     <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_sat_q   <= 1'b0;
    end else if (adv_s) begin
      s1_valid_q  <= in_valid;
      s1_neg_q    <= s1_neg_d;
      s1_y_q      <= s1_y_d;
      s2_valid_q  <= s1_valid_q;
      s2_neg_q    <= s1_neg_q;
      s2_sat_q    <= s2_sat_d;
      s2_dif_q    <= s2_dif_d;
      s2_sh_q     <= s2_sh_d;
      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Saturation counter: clear wins over a same-cycle increment, and it sticks at all-ones.
  always_comb begin
    if (sat_clr) begin
      sat_count_d = {SAT_CNT_W{1'b0}};
    end else if (out_valid_q && out_ready && out_sat_q &&
                 (sat_count_q != {SAT_CNT_W{1'b1}})) begin
      sat_count_d = sat_count_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= {SAT_CNT_W{1'b0}};
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sigmoid_inverse.sv
// Self-checking bench for sigmoid_inverse: arithmetic reference model with a scoreboard
// checked every cycle, plus directed literal expectations.
module tb_sigmoid_inverse;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sat;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [15:0] sat_m = 16'h0000;
  logic        rnd_en = 1'b0;
  logic        rdy_fixed = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_sat = 1'b0;
  logic [31:0] last_d = 32'h0;
  logic        last_s = 1'b0;

  sigmoid_inverse #(.SAT_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Logit approximation straight from the segment table, in plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] y);
    int   p, q, x;
    bit   neg;
    exp_t r;
    p   = (y > 16'h1000) ? 4096 : int'(y);
    neg = (p < 2048);
    q   = neg ? 4096 - p : p;
    r.s = (q == 4096);
    if (r.s)            x = 5 * 4096;
    else if (q < 3072)  x = (q - 2048) * 4;
    else if (q < 3776)  x = (q - 2560) * 8;
    else                x = (q - 3456) * 32;
    if (neg) x = -x;
    r.d = 32'(x * 4096);
    return r;
  endfunction

  // Output ready: either a fixed level or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Scoreboard / per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic xfer_sat;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      sat_m = 16'h0000;
      stall_prev = 1'b0;
    end else begin
      xfer_sat = 1'b0;
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      chk("sat_count", 32'(sat_count), 32'(sat_m));
      if (stall_prev) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sat", 32'(out_sat), 32'(e.s));
          xfer_sat = e.s;
          last_d = out_data;
          last_s = out_sat;
        end
      end
      if (sat_clr) sat_m = 16'h0000;
      else if (xfer_sat && sat_m != 16'hFFFF) sat_m = sat_m + 16'h0001;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic send(input logic [15:0] y);
    int n = 0;
    in_valid = 1'b1;
    in_data  = y;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    // Pin the reference model to hand-computed points.
    m = model(16'h0800); chk("model_0800", m.d, 32'h0000_0000);
    m = model(16'h0EC0); chk("model_0EC0", m.d, 32'h0280_0000);
    m = model(16'h0000); chk("model_0000", m.d, 32'hFB00_0000);
    m = model(16'hFFFF); chk("model_FFFF", {m.d[31:1], m.s}, 32'h0500_0001);

    // Reset state.
    #3;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_sat", 32'(out_sat), 32'h0);
    chk("reset_count", 32'(sat_count), 32'h0);
    rdy_fixed = 1'b1;
    #20;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // T1: back-to-back, exact latency and values.
    in_valid = 1'b1; in_data = 16'h0800;
    @(posedge clk); #1; in_data = 16'h0A00;
    @(posedge clk); #1; in_data = 16'h0C00;
    @(negedge clk); chk("t1_lat_early", 32'(out_valid), 32'h0);
    @(posedge clk); #1; in_data = 16'h0F00;
    @(negedge clk); chk("t1_o0", {out_data[31:1], out_valid}, 32'h0000_0001);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("t1_o1", out_data, 32'h0080_0000);
    @(posedge clk); @(negedge clk); chk("t1_o2", out_data, 32'h0100_0000);
    @(posedge clk); @(negedge clk); chk("t1_o3", out_data, 32'h0300_0000);
    chk("t1_sat", 32'(out_sat), 32'h0);
    @(posedge clk); @(negedge clk); chk("t1_done", 32'(out_valid), 32'h0);
    @(posedge clk); #1;

    // T2: negative side and lower saturation.
    send(16'h0400);
    send(16'h0000);
    drain();
    chk("t2_last_data", last_d, 32'hFB00_0000);
    chk("t2_last_sat", 32'(last_s), 32'h1);

    // T3: upper saturation, bit15 clamp, segment boundary.
    pulse_clr();
    send(16'h1000);
    send(16'h8123);
    send(16'h0EC0);
    drain();
    chk("t3_last_data", last_d, 32'h0280_0000);
    chk("t3_last_sat", 32'(last_s), 32'h0);
    chk("t3_count", 32'(sat_count), 32'h2);

    // T4: random back-pressure.
    rnd_en = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(i * 16'h0233));
    repeat (20) @(posedge clk);
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain();

    // T5: saturating counter holds at all-ones; clear beats a concurrent increment.
    pulse_clr();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    repeat (65537 + 3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("t5_hold", 32'(sat_count), 32'h0000_FFFF);
    send(16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_pending_sat", {31'h0, out_valid & out_sat}, 32'h1);
    pulse_clr();
    @(negedge clk);
    chk("t5_clr_priority", 32'(sat_count), 32'h0);
    @(posedge clk); #1;

    // T6: reset with three items in flight.
    send(16'h0900);
    send(16'h0B00);
    send(16'h0D00);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_stale", 32'(out_valid), 32'h0);

    // Full sweep against the reference model.
    for (int y = 0; y <= 16'h1000; y++) send(16'(y));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
